// File: rtl/max_unpooling_mult.sv
// max_unpooling_mult: scatters a pooled gradient vector back to 2x width using a stored per-pair argmax mask
module max_unpooling_mult #(
    parameter int NUM_OUT = 24,
    parameter int DATA_W  = 32,
    parameter int LANES   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mask_valid_i,
    input  logic [NUM_OUT-1:0]            mask_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [NUM_OUT*DATA_W-1:0]     multi_input_data,
    output logic                          valid_o,
    output logic [2*NUM_OUT*DATA_W-1:0]   multi_output_data
);
    localparam int STEPS = NUM_OUT / LANES;
    localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      state;
    logic [NUM_OUT-1:0]          shadow_mask;
    logic [NUM_OUT-1:0]          active_mask;
    logic                        mask_loaded;
    logic [CW-1:0]               cnt;
    logic [NUM_OUT*DATA_W-1:0]   in_r;
    logic [DATA_W-1:0]           out_w [2*NUM_OUT];

    assign ready_o = state == IDLE && mask_loaded;

    // shadow mask: any load is kept until the next frame is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mask <= '0;
            mask_loaded <= 1'b0;
        end else if (mask_valid_i) begin
            shadow_mask <= mask_i;
            mask_loaded <= 1'b1;
        end
    end

    // frame sequencer: accept, walk LANES pairs per cycle, pulse completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            active_mask <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: if (valid_i && ready_o) begin
                    active_mask <= mask_valid_i ? mask_i : shadow_mask;
                    in_r        <= multi_input_data;
                    cnt         <= '0;
                    state       <= BUSY;
                end
                BUSY: if (cnt == CW'(STEPS - 1)) begin
                    state   <= DONE;
                    valid_o <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_OUT; p++) begin : g_pair
        logic hit;
        assign hit = state == BUSY && cnt == CW'(p / LANES);
        // pair p: gradient to the forward winner, zero to its partner
        always_ff @(posedge clk) begin
            if (reset) begin
                out_w[2*p]   <= '0;
                out_w[2*p+1] <= '0;
            end else if (hit) begin
                out_w[2*p]   <= active_mask[p] ? '0 : in_r[p*DATA_W +: DATA_W];
                out_w[2*p+1] <= active_mask[p] ? in_r[p*DATA_W +: DATA_W] : '0;
            end
        end
        assign multi_output_data[2*p*DATA_W +: DATA_W]     = out_w[2*p];
        assign multi_output_data[(2*p+1)*DATA_W +: DATA_W] = out_w[2*p+1];
    end
endmodule

// File: tb/tb_max_unpooling_mult.sv
// tb_max_unpooling_mult: scoreboard bench for the mask-driven unpooling scatter
module tb_max_unpooling_mult;
    localparam int N = 24;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mask_valid_i = 1'b0;
    logic [N-1:0]     mask_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [N*W-1:0]   din = '0;
    logic             valid_o;
    logic [2*N*W-1:0] dout;

    int total = 0;
    int bad = 0;
    logic [N-1:0] shadow = '0;
    logic [2*N*W-1:0] exp_q[$];
    logic [2*N*W-1:0] e;
    int lat;
    logic ok;

    max_unpooling_mult #(.NUM_OUT(N), .DATA_W(W), .LANES(4)) dut (
        .clk(clk), .reset(reset), .mask_valid_i(mask_valid_i), .mask_i(mask_i),
        .valid_i(valid_i), .ready_o(ready_o), .multi_input_data(din),
        .valid_o(valid_o), .multi_output_data(dout)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N*W-1:0] model(input logic [N*W-1:0] d, input logic [N-1:0] m);
        logic [2*N*W-1:0] r = '0;
        for (int k = 0; k < N; k++)
            if (m[k]) r[(2*k+1)*W +: W] = d[k*W +: W];
            else      r[2*k*W +: W]     = d[k*W +: W];
        return r;
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] base, input logic [W-1:0] step);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = base + step * W'(k);
        return r;
    endfunction

    task automatic load_mask(input logic [N-1:0] m);
        @(negedge clk);
        mask_valid_i = 1'b1;
        mask_i = m;
        @(negedge clk);
        mask_valid_i = 1'b0;
        shadow = m;
    endtask

    task automatic start_frame(input logic [N*W-1:0] d, input logic with_mask, input logic [N-1:0] m, output logic acc);
        @(negedge clk);
        din = d;
        valid_i = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        if (with_mask) begin mask_valid_i = 1'b1; mask_i = m; shadow = m; end
        if (acc) exp_q.push_back(model(d, shadow));
        @(negedge clk);
        valid_i = 1'b0;
        mask_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!valid_o && n < 40) begin @(negedge clk); n++; end
    endtask

    task automatic pop_exp();
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (dout !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", dout); end
    endtask

    task automatic test_no_mask();
        din = fill(32'h1234_5678, 32'h1);
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
                bad++; $display("FAIL no_mask_cycle%0d valid=%b ready=%b exp 0/0", i, valid_o, ready_o);
            end
        end
        valid_i = 1'b0;
        total++; if (dout !== '0) begin bad++; $display("FAIL no_mask_out got=%h exp=0", dout); end
    endtask

    task automatic test_mask_zero();
        load_mask('0);
        start_frame(fill(32'h3F80_0000, 0), 1'b0, '0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_accept got=%b exp=1", ok); end
        wait_valid(lat);
        total++; if (lat != 7) begin bad++; $display("FAIL zero_latency got=%0d exp=7", lat); end
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL zero_data got=%h exp=%h", dout, e); end
        total++; if (dout[0 +: W] !== 32'h3F80_0000 || dout[W +: W] !== 32'h0) begin
            bad++; $display("FAIL zero_pair0 got=%h_%h exp=00000000_3f800000", dout[W +: W], dout[0 +: W]);
        end
        total++; if (dout[46*W +: W] !== 32'h3F80_0000 || dout[47*W +: W] !== 32'h0) begin
            bad++; $display("FAIL zero_pair23 got=%h_%h exp=00000000_3f800000", dout[47*W +: W], dout[46*W +: W]);
        end
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b exp=0", valid_o); end
    endtask

    task automatic test_alt_mask();
        load_mask(24'hAAAAAA);
        start_frame(fill(0, 1), 1'b0, '0, ok);
        wait_valid(lat);
        total++; if (lat != 7) begin bad++; $display("FAIL alt_latency got=%0d exp=7", lat); end
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL alt_data got=%h exp=%h", dout, e); end
        total++; if (dout[2*W +: W] !== 32'd0 || dout[3*W +: W] !== 32'd1 || dout[4*W +: W] !== 32'd2 || dout[5*W +: W] !== 32'd0) begin
            bad++; $display("FAIL alt_words2to5 got=%h %h %h %h exp=0 1 2 0", dout[2*W +: W], dout[3*W +: W], dout[4*W +: W], dout[5*W +: W]);
        end
        repeat (3) @(negedge clk);
        total++; if (dout !== e) begin bad++; $display("FAIL alt_hold got=%h exp=%h", dout, e); end
    endtask

    task automatic test_mask_during_busy();
        load_mask('0);
        start_frame(fill(32'h8000_0001, 32'h1), 1'b0, '0, ok);
        @(negedge clk);
        load_mask('1);
        wait_valid(lat);
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL busy_load_cur got=%h exp=%h", dout, e); end
        total++; if (dout[0 +: W] !== 32'h8000_0001) begin bad++; $display("FAIL busy_load_word0 got=%h exp=80000001", dout[0 +: W]); end
        start_frame(fill(32'h7FC0_0000, 32'h3), 1'b0, '0, ok);
        wait_valid(lat);
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL busy_load_next got=%h exp=%h", dout, e); end
        total++; if (dout[0 +: W] !== 32'h0 || dout[W +: W] !== 32'h7FC0_0000) begin
            bad++; $display("FAIL busy_load_pair0 got=%h_%h exp=7fc00000_00000000", dout[W +: W], dout[0 +: W]);
        end
    endtask

    task automatic test_same_cycle_mask();
        start_frame(fill(32'h0000_0001, 32'h0101_0101), 1'b1, 24'h0F0F0F, ok);
        wait_valid(lat);
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL same_cycle_mask got=%h exp=%h", dout, e); end
    endtask

    task automatic test_back_to_back();
        int fi = 0;
        int done_n = 0;
        int last = -1;
        logic pv = 1'b0;
        load_mask('0);
        @(negedge clk);
        din = fill(32'h4000_0000, 32'h10);
        valid_i = 1'b1;
        for (int c = 0; c < 80 && done_n < 4; c++) begin
            if (valid_o) begin
                pop_exp();
                done_n++;
                total++; if (dout !== e) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", done_n, dout, e); end
                total++; if (pv || ready_o) begin bad++; $display("FAIL b2b_pulse%0d prev_valid=%b ready=%b exp 0/0", done_n, pv, ready_o); end
            end
            if (ready_o) begin
                if (last >= 0) begin
                    total++; if (c - last != 8) begin bad++; $display("FAIL b2b_period got=%0d exp=8", c - last); end
                end
                last = c;
                exp_q.push_back(model(din, shadow));
                fi++;
            end else begin
                din = fill(32'h4000_0000 + W'(fi) * 32'h100, 32'h10);
            end
            pv = valid_o;
            @(negedge clk);
        end
        valid_i = 1'b0;
        total++; if (done_n != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", done_n); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        load_mask(24'h5A3C96);
        start_frame(fill(32'hC0DE_0000, 32'h7), 1'b0, '0, ok);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        shadow = '0;
        total++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL midreset_ctrl ready=%b valid=%b exp 0/0", ready_o, valid_o); end
        total++; if (dout !== '0) begin bad++; $display("FAIL midreset_out got=%h exp=0", dout); end
        valid_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++;
            if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
                bad++; $display("FAIL midreset_idle%0d valid=%b ready=%b exp 0/0", i, valid_o, ready_o);
            end
        end
        valid_i = 1'b0;
        load_mask(24'h123456);
        start_frame(fill(32'h0080_0000, 32'h11), 1'b0, '0, ok);
        wait_valid(lat);
        total++; if (lat != 7) begin bad++; $display("FAIL midreset_latency got=%0d exp=7", lat); end
        pop_exp();
        total++; if (dout !== e) begin bad++; $display("FAIL midreset_data got=%h exp=%h", dout, e); end
    endtask

    initial begin
        test_reset();
        test_no_mask();
        test_mask_zero();
        test_alt_mask();
        test_mask_during_busy();
        test_same_cycle_mask();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
